// File: rtl/pq_arb.sv
// Round-robin arbiter/sequencer sharing one priority-queue device among N_REQ requesters.
// Latency: request sampled in IDLE at t, PQ strobe at t+1, ack at t+2 (zero-busy PQ).
// Backpressure: requests wait while PQ is full/empty/busy; WAIT holds until pq_busy drops.
// Optional feature macro: PQ_ARB_LOCK_EN (lock holder keeps strict priority across ops).
module pq_arb #(
    parameter  int N_REQ = 4,
    parameter  int KV_W  = 32,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_enq,
    input  logic [N_REQ-1:0]        req_deq,
    input  logic [N_REQ*KV_W-1:0]   req_kvi,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        req_ack,
    output logic [KV_W-1:0]         resp_kv,
    output logic                    gnt_valid,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    pq_enq,
    output logic                    pq_deq,
    output logic [KV_W-1:0]         pq_kvi,
    input  logic [KV_W-1:0]         pq_kvo,
    input  logic                    pq_full,
    input  logic                    pq_empty,
    input  logic                    pq_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [IDX_W-1:0]   rr_inc;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_valid_q;
    logic               op_enq_q;
    logic               op_deq_q;
    logic               pq_enq_q;
    logic               pq_deq_q;
    logic [KV_W-1:0]    pq_kvi_q;
    logic [KV_W-1:0]    resp_kv_q;

    logic [N_REQ-1:0]   elig;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [KV_W-1:0]    win_kvi;

    // A request is eligible only if the PQ can accept that operation right now.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = !pq_busy &&
                      ((req_enq[i] && !req_deq[i] && !pq_full) ||
                       (req_deq[i] && !pq_empty));
        end
    end

    // Scan from the highest offset down so the offset closest to rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int s;
            s = int'(rr_ptr_q) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (elig[IDX_W'(s)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(s);
            end
        end
    end

    assign win_kvi = req_kvi[int'(win_idx) * KV_W +: KV_W];

    // Next round-robin pointer; explicit wrap keeps non-power-of-2 N_REQ in range.
    always_comb begin
        rr_inc = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
`ifdef PQ_ARB_LOCK_EN
        rr_ptr_d = req_lock[gnt_idx_q] ? gnt_idx_q : rr_inc;
`else
        rr_ptr_d = rr_inc;
`endif
    end

`ifndef PQ_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Ack is decoded from WAIT so it lands in the same cycle the PQ reports idle.
    always_comb begin
        req_ack = '0;
        if (state_q == WAIT && !pq_busy) req_ack[gnt_idx_q] = 1'b1;
    end

    // Sequencer: grant in IDLE, one-cycle strobe in ISSUE, hold in WAIT until idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            op_enq_q    <= 1'b0;
            op_deq_q    <= 1'b0;
            pq_enq_q    <= 1'b0;
            pq_deq_q    <= 1'b0;
            pq_kvi_q    <= '0;
            resp_kv_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        gnt_idx_q   <= win_idx;
                        gnt_valid_q <= 1'b1;
                        op_enq_q    <= req_enq[win_idx];
                        op_deq_q    <= req_deq[win_idx];
                        pq_enq_q    <= req_enq[win_idx];
                        pq_deq_q    <= req_deq[win_idx];
                        pq_kvi_q    <= win_kvi;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Head is captured before the dequeue strobe takes effect.
                    resp_kv_q <= pq_kvo;
                    pq_enq_q  <= 1'b0;
                    pq_deq_q  <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (!pq_busy) begin
                        rr_ptr_q    <= rr_ptr_d;
                        gnt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_kv   = resp_kv_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign pq_enq    = pq_enq_q;
    assign pq_deq    = pq_deq_q;
    assign pq_kvi    = pq_kvi_q;

endmodule

// File: tb/tb_pq_arb.sv
// Scoreboard bench for pq_arb: expected acks queued at stimulus, popped on each ack.
// PQ status inputs are driven directly by the bench to create full/empty/busy cases.
// Inputs change #1 after posedge; outputs are sampled on the negedge.
module tb_pq_arb;

    localparam int N  = 4;
    localparam int KW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_enq = '0;
    logic [N-1:0]      req_deq = '0;
    logic [N*KW-1:0]   req_kvi = '0;
    logic [N-1:0]      req_lock = '0;
    logic [N-1:0]      req_ack;
    logic [KW-1:0]     resp_kv;
    logic              gnt_valid;
    logic [1:0]        gnt_idx;
    logic              pq_enq;
    logic              pq_deq;
    logic [KW-1:0]     pq_kvi;
    logic [KW-1:0]     pq_kvo = '0;
    logic              pq_full = 1'b0;
    logic              pq_empty = 1'b1;
    logic              pq_busy = 1'b0;

    pq_arb #(.N_REQ(N), .KV_W(KW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_enq(req_enq), .req_deq(req_deq), .req_kvi(req_kvi), .req_lock(req_lock),
        .req_ack(req_ack), .resp_kv(resp_kv), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ack;
        bit           chk_kv;
        logic [KW-1:0] kv;
        int           gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ncyc = 0;
    int   last_ack = 0;
    int   strobe_cnt = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int idx, input bit ck, input logic [KW-1:0] kv, input int gap);
        exp_t e;
        e.ack    = N'(1) << idx;
        e.chk_kv = ck;
        e.kv     = kv;
        e.gap    = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n, output int idx);
        n = 0;
        idx = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (req_ack != '0) begin
                for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
                return;
            end
        end
        chk_eq("ack_timeout", 64'(n), 64'(0));
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk_eq({pfx, "_ack"},   64'(req_ack),   64'(0));
        chk_eq({pfx, "_resp"},  64'(resp_kv),   64'(0));
        chk_eq({pfx, "_gv"},    64'(gnt_valid), 64'(0));
        chk_eq({pfx, "_gidx"},  64'(gnt_idx),   64'(0));
        chk_eq({pfx, "_enq"},   64'(pq_enq),    64'(0));
        chk_eq({pfx, "_deq"},   64'(pq_deq),    64'(0));
        chk_eq({pfx, "_kvi"},   64'(pq_kvi),    64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk_zero_outs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every ack must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst_n) begin
            if (pq_enq || pq_deq) strobe_cnt++;
            if (req_ack != '0) begin
                if (sb.size() == 0) begin
                    chk_eq("unexp_ack", 64'(req_ack), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk_eq("ack_onehot", 64'(req_ack), 64'(e.ack));
                    if (e.chk_kv) chk_eq("resp_kv", 64'(resp_kv), 64'(e.kv));
                    if (e.gap != 0) chk_eq("ack_gap", 64'(ncyc - last_ack), 64'(e.gap));
                end
                last_ack = ncyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n, idx, s0;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();

        // Single enqueue: strobe at t+1, ack at t+2, one strobe
        tick();
        req_kvi[0 +: KW] = 32'h0005_00AA;
        req_enq = 4'b0001;
        push_exp(0, 1'b0, '0, 0);
        s0 = strobe_cnt;
        @(negedge clk);
        chk_eq("t1_idle_enq", 64'(pq_enq), 64'(0));
        @(negedge clk);
        chk_eq("t1_pq_enq", 64'(pq_enq), 64'(1));
        chk_eq("t1_pq_deq", 64'(pq_deq), 64'(0));
        chk_eq("t1_pq_kvi", 64'(pq_kvi), 64'(32'h0005_00AA));
        chk_eq("t1_gv", 64'(gnt_valid), 64'(1));
        wait_ack(20, n, idx);
        chk_eq("t1_lat", 64'(n), 64'(1));
        req_enq = '0;
        repeat (3) @(negedge clk);
        chk_eq("t1_one_strobe", 64'(strobe_cnt - s0), 64'(1));

        // Round-robin with all requesters holding enq
        do_reset();
        for (int i = 0; i < N; i++) req_kvi[i*KW +: KW] = 32'h1000_0000 + i;
        req_enq = 4'hF;
        push_exp(0, 1'b0, '0, 0);
        push_exp(1, 1'b0, '0, 3);
        push_exp(2, 1'b0, '0, 3);
        push_exp(3, 1'b0, '0, 3);
        push_exp(0, 1'b0, '0, 3);
        for (int k = 0; k < 5; k++) begin
            wait_ack(20, n, idx);
            chk_eq("t2_order", 64'(idx), 64'(order[k]));
        end
        req_enq = '0;
        repeat (3) @(negedge clk);

        // Full/empty skip: deq granted while full, enq pending until not full
        do_reset();
        pq_full = 1'b1;
        pq_empty = 1'b0;
        pq_kvo = 32'h0001_0011;
        req_enq = 4'b0010;
        req_deq = 4'b0100;
        push_exp(2, 1'b1, 32'h0001_0011, 0);
        wait_ack(20, n, idx);
        chk_eq("t3_first", 64'(idx), 64'(2));
        req_deq = '0;
        repeat (6) @(negedge clk);
        chk_eq("t3_pending_gv", 64'(gnt_valid), 64'(0));
        tick();
        pq_full = 1'b0;
        push_exp(1, 1'b0, '0, 0);
        wait_ack(20, n, idx);
        chk_eq("t3_second", 64'(idx), 64'(1));
        req_enq = '0;
        pq_empty = 1'b1;
        repeat (2) @(negedge clk);

        // Busy stall: five busy cycles in WAIT, ack on the first idle cycle
        tick();
        req_enq = 4'b0001;
        push_exp(0, 1'b0, '0, 0);
        s0 = strobe_cnt;
        @(negedge clk);
        @(negedge clk);
        chk_eq("t4_strobe", 64'(pq_enq), 64'(1));
        @(posedge clk);
        #1 pq_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_eq("t4_wait_noack", 64'(req_ack), 64'(0));
            chk_eq("t4_wait_gv", 64'(gnt_valid), 64'(1));
        end
        @(posedge clk);
        #1 pq_busy = 1'b0;
        wait_ack(20, n, idx);
        chk_eq("t4_ack_lat", 64'(n), 64'(1));
        req_enq = '0;
        repeat (3) @(negedge clk);
        chk_eq("t4_one_strobe", 64'(strobe_cnt - s0), 64'(1));

        // Replace, then async reset while in WAIT
        do_reset();
        pq_empty = 1'b0;
        pq_kvo = 32'h0000_1234;
        req_kvi[3*KW +: KW] = 32'hCAFE_0003;
        req_enq = 4'b1000;
        req_deq = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk_eq("t5_enq", 64'(pq_enq), 64'(1));
        chk_eq("t5_deq", 64'(pq_deq), 64'(1));
        chk_eq("t5_kvi", 64'(pq_kvi), 64'(32'hCAFE_0003));
        @(posedge clk);
        #1 pq_busy = 1'b1;
        @(negedge clk);
        chk_eq("t5_gv", 64'(gnt_valid), 64'(1));
        chk_eq("t5_gidx", 64'(gnt_idx), 64'(3));
        chk_eq("t5_resp", 64'(resp_kv), 64'(32'h0000_1234));
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outs("t5_arst");
        req_enq = '0;
        req_deq = '0;
        pq_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        req_enq = 4'b1010;
        push_exp(1, 1'b0, '0, 0);
        push_exp(3, 1'b0, '0, 0);
        wait_ack(20, n, idx);
        chk_eq("t5_post_first", 64'(idx), 64'(1));
        req_enq = 4'b1000;
        wait_ack(20, n, idx);
        chk_eq("t5_post_second", 64'(idx), 64'(3));
        req_enq = '0;
        pq_empty = 1'b1;
        repeat (3) @(negedge clk);

`ifdef PQ_ARB_LOCK_EN
        // Lock: r1 keeps the grant while locked, then r2, then r0
        do_reset();
        req_enq = 4'b0010;
        req_lock = 4'b0010;
        push_exp(1, 1'b0, '0, 0);
        push_exp(1, 1'b0, '0, 0);
        push_exp(1, 1'b0, '0, 0);
        push_exp(2, 1'b0, '0, 0);
        push_exp(0, 1'b0, '0, 0);
        wait_ack(20, n, idx);
        chk_eq("t6_lock1", 64'(idx), 64'(1));
        req_enq = 4'b0111;
        wait_ack(20, n, idx);
        chk_eq("t6_lock2", 64'(idx), 64'(1));
        req_lock = '0;
        wait_ack(20, n, idx);
        chk_eq("t6_lock3", 64'(idx), 64'(1));
        req_enq = 4'b0101;
        wait_ack(20, n, idx);
        chk_eq("t6_after_r2", 64'(idx), 64'(2));
        req_enq = 4'b0001;
        wait_ack(20, n, idx);
        chk_eq("t6_after_r0", 64'(idx), 64'(0));
        req_enq = '0;
        repeat (3) @(negedge clk);
`endif

        chk_eq("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pq_arb.md
Name: pq_arb

Overview:
- Round-robin arbiter and sequencer that shares one priority-queue device among N_REQ requesters.
- Each requester posts an enqueue, dequeue or replace; the arbiter checks it against the PQ's full/empty/busy status, issues it as a one-cycle strobe, waits for the PQ to go idle, then acks the requester.
- For dequeue and replace, the ack carries the dequeued key-value pair.
- Sits between client logic and any PQ implementation (heap, shift-register, ...).

Parameters:
N_REQ, 4, number of requesters (2..16)
KV_W, 32, width of one key-value pair (key in MSBs, smaller key = higher priority)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_enq  in  N_REQ  per-requester enqueue request, level, held until ack
req_deq  in  N_REQ  per-requester dequeue request, level, held until ack; enq+deq together = replace
req_kvi  in  N_REQ*KV_W  per-requester enqueue data, slice i = bits [i*KV_W +: KV_W]
req_lock  in  N_REQ  keep-grant request (used only with PQ_ARB_LOCK_EN)
req_ack  out  N_REQ  one-cycle completion pulse, one-hot
resp_kv  out  KV_W  pair removed by the last dequeue/replace, valid while req_ack is high
gnt_valid  out  1  high while an operation is in flight (ISSUE or WAIT)
gnt_idx  out  $clog2(N_REQ)  index of current or last grantee
pq_enq  out  1  PQ enqueue strobe
pq_deq  out  1  PQ dequeue strobe
pq_kvi  out  KV_W  PQ enqueue data
pq_kvo  in  KV_W  PQ head (minimum) pair
pq_full  in  1  PQ full
pq_empty  in  1  PQ empty
pq_busy  in  1  PQ multi-cycle operation in progress

Behaviour:
- Reset (async, rst_n low): state IDLE, rr_ptr=0. All outputs 0: req_ack, resp_kv, gnt_valid, gnt_idx, pq_enq, pq_deq, pq_kvi.
- Eligibility of requester i, evaluated in IDLE:
  - enq only: requires !pq_full.
  - deq only or replace: requires !pq_empty.
  - Nothing eligible while pq_busy=1.
  - Ineligible requests are skipped, never dropped.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first eligible index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On a winner: latch gnt_idx, op bits, and that requester's kvi slice; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - pq_enq/pq_deq reflect the latched op; pq_kvi = latched kvi.
  - resp_kv <= pq_kvo, sampled before the dequeue takes effect.
  - Go to WAIT.
- WAIT:
  - Strobes 0. When pq_busy=0, assert req_ack[gnt_idx] for 1 cycle, set rr_ptr <= (gnt_idx+1) mod N_REQ, go to IDLE.
  - Otherwise stay in WAIT. No timeout.
- Latency with a zero-busy PQ: request sampled in IDLE at cycle t, strobe at t+1, ack at t+2. Next grant no earlier than t+3.
- Requester rules: drop or change its request no later than the cycle after ack. Request changes during ISSUE/WAIT are ignored (op latched).
- Enq-only op: resp_kv is also updated in ISSUE; the value is don't-care for the requester.
- gnt_valid is high in ISSUE and WAIT only.
- rr_ptr wraps N_REQ-1 -> 0. rr_ptr width is $clog2(N_REQ); when N_REQ is not a power of 2, the increment wraps explicitly.
- Reset asserted mid-operation: FSM returns to IDLE immediately, strobes drop, no ack is issued.

Optional Feature:
- Macro PQ_ARB_LOCK_EN.
- When defined:
  - If req_lock[gnt_idx]=1 in the ack cycle, rr_ptr is not advanced.
  - The next IDLE gives that requester strict priority if it is eligible.
  - A lock holder may therefore perform back-to-back atomic sequences.
  - Lock is released by acking with req_lock low.
- When undefined: req_lock is ignored and the policy is pure round-robin.

Test Plan:
- Single enq: r0 enq kvi=0x0005_00AA, PQ empty, busy=0 -> pq_enq=1 with pq_kvi=0x0005_00AA at t+1; req_ack=4'b0001 at t+2; exactly one strobe.
- Round-robin: r0..r3 all request enq continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each ack 3 cycles apart.
- Full/empty skip: pq_full=1, r1 enq, r2 deq, PQ head 0x0001_0011 -> r2 granted first, resp_kv=0x0001_0011 with ack; r1 stays pending until pq_full=0, then granted.
- Busy stall: PQ holds pq_busy=1 for 5 cycles after the strobe -> FSM stays in WAIT 5 cycles; ack in the first cycle busy=0; no new strobe meanwhile.
- Replace + reset: r3 enq+deq (replace) -> pq_enq and pq_deq high in the same cycle; async rst_n low during WAIT -> all outputs 0 immediately, no ack, rr_ptr=0.
- (PQ_ARB_LOCK_EN) r1 locked and repeating enq while r0, r2 request -> r1 granted consecutively until req_lock[1]=0, then r2, then r0.
